pulse_stretcher: RTL
====================

// Module: pulse_stretcher
// PURPOSE
//  Output-side counterpart to input conditioning. Turns single-cycle event strobes into clean, human/relay-visible pulses.
//  Each strobe yields one pulse of HIGH_TICKS cycles, followed by a LOW_TICKS minimum gap.
//  Strobes arriving while a pulse or gap is in progress are queued in a saturating pending counter.
//  Drives LEDs, buzzers and relays from fabric events.
// PARAMETERS
//  HIGH_TICKS  1000  pulse high time in clk cycles (>=1)
//  LOW_TICKS   1000  minimum low time after each pulse in clk cycles (>=1)
//  MAX_PEND    15    max queued strobes beyond the active one (>=1); pending counter saturates here
// PORTS
//  clk   in   1                      system clock; all logic on posedge
//  rst   in   1                      synchronous, active-high reset
//  stb   in   1                      event strobe, sampled every cycle; each high cycle = one event
//  o     out  1                      stretched pulse output, registered
//  busy  out  1                      high whenever state != IDLE, registered
//  pend  out  $clog2(MAX_PEND+1)     current pending-event count
//  ovf   out  1                      sticky drop flag; present only with PULSE_STRETCHER_OVF_EN
// BEHAVIOUR
//  Reset: state=IDLE, o=0, busy=0, pend=0, timer=0, ovf=0. stb is ignored while rst=1.
//  Reset mid-pulse or mid-gap aborts it: o=0 on the cycle after rst is sampled, and the queue is flushed.
//  FSM states: IDLE, HIGH, GAP.
//   IDLE: stb=1 or pend!=0 -> HIGH next cycle, o=1, timer=0. Latency from stb to rising o is 1 cycle.
//   HIGH: o=1 for exactly HIGH_TICKS cycles. On the last one -> GAP, o=0, timer=0.
//   GAP: o=0 for exactly LOW_TICKS cycles. On the last one:
//    - (pend!=0 or stb=1) -> HIGH directly, with no IDLE cycle in between;
//    - otherwise -> IDLE.
//  Event accounting:
//   - An event is consumed on the transition into HIGH.
//   - A strobe accepted in the same cycle it starts a pulse is not queued.
//   - stb while HIGH/GAP: pend+1 if pend<MAX_PEND, else the event is dropped.
//   - stb in the same cycle a queued event is consumed: pend unchanged (net 0).
//   - pend never wraps; it saturates at MAX_PEND.
//  Timer: single counter sized $clog2(max(HIGH_TICKS,LOW_TICKS)+1); cleared on every state change; no wrap.
//  busy and o are registered outputs; there is no combinational path from stb to any output.
// CONFIGURATION
//  PULSE_STRETCHER_OVF_EN defined:
//   - ovf port exists;
//   - ovf is set the cycle after a strobe is dropped at saturation;
//   - ovf stays set until rst.
//  PULSE_STRETCHER_OVF_EN undefined: no ovf port and no flag logic; drops are silent.
// STRUCTURE
//  Shared package hdl_generics_pkg holds:
//   - typedef enum logic [1:0] {PS_IDLE, PS_HIGH, PS_GAP} ps_state_t;
//   - function int max2(int a, int b), used for timer width.
//  Sub-module tick_timer #(MAX) provides clear/enable, a count output and a done pulse at MAX-1.
//  It is instantiated once; its MAX is muxed per state via the terminal compare.
//  Top level holds the FSM, pend counter and ovf.
// TESTING (HIGH_TICKS=4, LOW_TICKS=3, MAX_PEND=2, cycle numbers = posedge index)
//  1. Single pulse: stb@10 -> o=1 cycles 11..14, o=0 from 15; busy=1 cycles 11..17, busy=0 @18; pend=0 throughout.
//  2. Queueing: stb@10,11,12 -> pend=2 after 12.
//     o high 11..14, 18..21 and 25..28; pend decrements at 18 and at 25.
//  3. Saturation: stb@10..13 -> pend holds 2 and the 4th strobe is dropped; exactly 3 pulses.
//     With macro: ovf=1 from 14 until rst. Without macro: no ovf port.
//  4. Back-to-back: single stb@10, then stb@17 (last GAP cycle) -> o=1 @18..21 with no IDLE cycle; pend stays 0.
//  5. Reset mid-op: stb@10,11, rst=1 @12 with stb=1 @12 -> @13 o=0, busy=0, pend=0.
//     No further pulses after rst falls.
//  6. Minimum params: HIGH_TICKS=1, LOW_TICKS=1, stb held high 10..15 -> o toggles 1,0,1,0 from 11.
//     pend saturates at 2; the bench checks pulse/gap widths of exactly 1 cycle.

Source files
------------

// File: rtl/hdl_generics_pkg.sv
// Shared types and elaboration helpers for the pulse stretcher and its timer.
package hdl_generics_pkg;

    typedef enum logic [1:0] {PS_IDLE, PS_HIGH, PS_GAP} ps_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretcher_tick_timer.sv
// Clearable up-counter; done flags the MAX-1 count, where the count holds instead of wrapping.
module tick_timer #(
    parameter int MAX = 2,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         done
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    assign done = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !done) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into HIGH_TICKS pulses separated by LOW_TICKS gaps, queueing extras.
// Optional sticky drop flag ovf is built when PULSE_STRETCHER_OVF_EN is defined.
module pulse_stretcher
    import hdl_generics_pkg::*;
#(
    parameter int HIGH_TICKS = 1000,
    parameter int LOW_TICKS  = 1000,
    parameter int MAX_PEND   = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stb,
    output logic                           o,
    output logic                           busy,
    output logic [$clog2(MAX_PEND+1)-1:0]  pend
`ifdef PULSE_STRETCHER_OVF_EN
    ,
    output logic                           ovf
`endif
);

    localparam int TMAX = max2(HIGH_TICKS, LOW_TICKS);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(MAX_PEND + 1);

    localparam logic [TW-1:0] HIGH_LAST = TW'(HIGH_TICKS - 1);
    localparam logic [TW-1:0] LOW_LAST  = TW'(LOW_TICKS - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PEND);

    ps_state_t     state;
    ps_state_t     state_nx;
    logic [PW-1:0] pend_nx;
    logic [TW-1:0] tmr_count;
    logic [TW-1:0] phase_last;
    logic          tmr_done;
    logic          tmr_clr;
    logic          tmr_en;
    logic          phase_end;
    logic          have_evt;
    logic          start;
    logic          take_q;
    logic          queue;

    tick_timer #(
        .MAX (TMAX),
        .W   (TW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .count (tmr_count),
        .done  (tmr_done)
    );

    // One timer serves both phases; the per-state terminal value picks the phase length.
    always_comb begin
        phase_last = (state == PS_HIGH) ? HIGH_LAST : LOW_LAST;
        tmr_en     = (state != PS_IDLE);
        phase_end  = (tmr_count == phase_last) || tmr_done;
        have_evt   = stb || (pend != '0);
    end

    always_comb begin
        state_nx = state;
        case (state)
            PS_IDLE: if (have_evt) state_nx = PS_HIGH;
            PS_HIGH: if (phase_end) state_nx = PS_GAP;
            PS_GAP:  if (phase_end) state_nx = have_evt ? PS_HIGH : PS_IDLE;
            default: state_nx = PS_IDLE;
        endcase
    end

    // A strobe that itself starts a pulse with an empty queue is consumed directly, never queued.
    always_comb begin
        tmr_clr = (state_nx != state);
        start   = (state_nx == PS_HIGH) && (state != PS_HIGH);
        take_q  = start && (pend != '0);
        queue   = stb && !(start && (pend == '0));
        pend_nx = pend;
        if (queue && !take_q) begin
            if (pend != PEND_MAX) pend_nx = pend + PW'(1);
        end else if (take_q && !queue) begin
            pend_nx = pend - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PS_IDLE;
            o     <= 1'b0;
            busy  <= 1'b0;
            pend  <= '0;
        end else begin
            state <= state_nx;
            o     <= (state_nx == PS_HIGH);
            busy  <= (state_nx != PS_IDLE);
            pend  <= pend_nx;
        end
    end

`ifdef PULSE_STRETCHER_OVF_EN
    logic drop;

    assign drop = queue && !take_q && (pend == PEND_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule
